// File: rtl/secret_pkg.sv
// Shared constants, state encoding and character encoder for the secret-file loader.
package secret_pkg;

    localparam int unsigned DEFAULT_WORD_COUNT = 20;
    localparam int unsigned WORD_W             = 7;

    localparam logic [WORD_W-1:0] PLAY_CMD     = 7'h7F;
    localparam logic [WORD_W-1:0] SPACE_WORD   = 7'h40;
    localparam logic [WORD_W-1:0] UNKNOWN_WORD = 7'h5F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PLAY   = 2'd2
    } state_t;

    // Map one input byte to a display word; never produces PLAY_CMD.
    function automatic logic [WORD_W-1:0] ascii_to_word(input logic [7:0] in_data,
                                                        input logic       in_raw);
        logic [7:0] diff;
        diff = 8'h00;
        if (in_raw) begin
            return {1'b0, in_data[5:0]};
        end else if (in_data >= 8'h20 && in_data <= 8'h5E) begin
            diff = in_data - 8'h20;
            return {1'b1, diff[5:0]};
        end else if (in_data >= 8'h61 && in_data <= 8'h7A) begin
            diff = in_data - 8'h40;
            return {1'b1, diff[5:0]};
        end
        return UNKNOWN_WORD;
    endfunction

endpackage

// File: rtl/secret_word_buf.sv
// Message word store: sequential writes at the fill count, indexed read, bulk clear.
module secret_word_buf
    import secret_pkg::*;
#(
    parameter int unsigned WORD_COUNT = DEFAULT_WORD_COUNT,
    localparam int unsigned CNT_W     = $clog2(WORD_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clear,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_word_c,
    output logic [CNT_W-1:0]  count
);

    logic [WORD_W-1:0] mem [WORD_COUNT];
    logic              do_write;

    assign do_write = wr_en && !clear && (count < CNT_W'(WORD_COUNT));

    // Store the incoming word at the current fill position.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WORD_COUNT); i++) begin
            if (do_write && count == CNT_W'(i)) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Fill count; reset and clear discard the message.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (do_write) begin
            count <= count + CNT_W'(1);
        end
    end

    // Indexed read; out-of-range indices return zero.
    always_comb begin
        rd_word_c = '0;
        for (int i = 0; i < int'(WORD_COUNT); i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_word_c = mem[i];
            end
        end
    end

endmodule

// File: rtl/secret_file_loader.sv
// Encodes a host message into display words, streams it onto the display bus, then holds play.
module secret_file_loader
    import secret_pkg::*;
#(
    parameter int unsigned WORD_COUNT = DEFAULT_WORD_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_raw,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              send,
    output logic [WORD_W-1:0] dout,
    output logic              busy,
    output logic              playing
);

    localparam int unsigned CNT_W = $clog2(WORD_COUNT + 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   idx, idx_d;
    logic [CNT_W-1:0]   count, cnt_next;
    logic [WORD_W-1:0]  rd_word_c, word_c, wr_word;
    logic [WORD_W-1:0]  dout_d;
    logic               busy_d, playing_d, in_ready_d;
    logic               wr_en, buf_clear;

    assign wr_en   = in_valid && in_ready;
    assign wr_word = ascii_to_word(in_data, in_raw);

    secret_word_buf #(
        .WORD_COUNT (WORD_COUNT)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_word),
        .clear     (buf_clear),
        .rd_idx    (idx),
        .rd_word_c (rd_word_c),
        .count     (count)
    );

    // Positions past the stored message are padded with spaces.
    assign word_c = (idx < count) ? rd_word_c : SPACE_WORD;

    // State and stream index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        dout_d    = PLAY_CMD;
        busy_d    = 1'b0;
        buf_clear = 1'b0;
        unique case (state)
            IDLE, PLAY: begin
                if (send) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (idx == CNT_W'(WORD_COUNT)) begin
                    state_d   = PLAY;
                    buf_clear = 1'b1;
                end else begin
                    dout_d = word_c;
                    busy_d = 1'b1;
                    idx_d  = idx + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        playing_d = (state_d == PLAY);
        if (buf_clear) begin
            cnt_next = '0;
        end else if (wr_en) begin
            cnt_next = count + CNT_W'(1);
        end else begin
            cnt_next = count;
        end
        in_ready_d = (state_d != STREAM) && (cnt_next < CNT_W'(WORD_COUNT));
    end

    // Registered outputs toward host and display.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= PLAY_CMD;
            busy     <= 1'b0;
            playing  <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            dout     <= dout_d;
            busy     <= busy_d;
            playing  <= playing_d;
            in_ready <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_secret_file_loader.sv
// Directed bench for secret_file_loader with a queue-based reference model.
module tb_secret_file_loader;

    localparam int unsigned WC = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_raw = 1'b0;
    logic       in_valid = 1'b0;
    logic       send = 1'b0;
    logic       in_ready;
    logic [6:0] dout;
    logic       busy;
    logic       playing;

    int tests = 0;
    int fails = 0;

    secret_file_loader #(.WORD_COUNT(WC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_raw   (in_raw),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .send     (send),
        .dout     (dout),
        .busy     (busy),
        .playing  (playing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: fold lowercase first, then map the printable range.
    function automatic logic [6:0] model_enc(input logic [7:0] c, input bit raw);
        logic [7:0] u;
        if (raw) return 7'(c & 8'h3F);
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
        if (u >= 8'h20 && u <= 8'h5E) return 7'(u + 8'h20);
        return 7'h5F;
    endfunction

    // Reference model: stored message queue plus a queue of pending stream words.
    logic [6:0] stored[$];
    logic [6:0] out_q[$];
    bit         streaming = 1'b0;
    bit         model_ok = 1'b0;
    logic [6:0] exp_dout = 7'h7F;
    bit         exp_busy = 1'b0;
    bit         exp_play = 1'b0;
    bit         exp_ready = 1'b1;

    always @(posedge clk) begin
        bit ready_now;
        if (rst) begin
            stored.delete();
            out_q.delete();
            streaming = 1'b0;
            exp_dout  = 7'h7F;
            exp_busy  = 1'b0;
            exp_play  = 1'b0;
            model_ok  = 1'b1;
        end else begin
            ready_now = !streaming && (stored.size() < WC);
            if (streaming) begin
                if (out_q.size() > 0) begin
                    exp_dout = out_q.pop_front();
                    exp_busy = 1'b1;
                end else begin
                    exp_dout  = 7'h7F;
                    exp_busy  = 1'b0;
                    exp_play  = 1'b1;
                    streaming = 1'b0;
                    stored.delete();
                end
            end else begin
                if (in_valid && ready_now) stored.push_back(model_enc(in_data, in_raw));
                if (send) begin
                    streaming = 1'b1;
                    exp_play  = 1'b0;
                    for (int k = 0; k < int'(WC); k++)
                        out_q.push_back(k < stored.size() ? stored[k] : 7'h40);
                end
            end
        end
        exp_ready = !streaming && (stored.size() < WC);
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("dout", 32'(dout), 32'(exp_dout));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("playing", 32'(playing), 32'(exp_play));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
        end
    end

    logic [6:0] cap [WC];
    int         busy_cycles;

    task automatic write_char(input logic [7:0] c, input bit raw);
        @(negedge clk);
        in_data  = c;
        in_raw   = raw;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_raw   = 1'b0;
    endtask

    // Optionally write a char alongside send; optionally re-pulse send at word ign_at.
    task automatic stream_collect(input int ign_at, input bit with_char, input logic [7:0] ch);
        int w;
        @(negedge clk);
        send = 1'b1;
        if (with_char) begin
            in_data  = ch;
            in_valid = 1'b1;
        end
        @(negedge clk);
        send     = 1'b0;
        in_valid = 1'b0;
        chk("dout_hold_after_send", 32'(dout), 32'h7F);
        w = 0;
        while (!busy && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("stream_start_timeout", 32'(busy), 32'h1);
        busy_cycles = 0;
        for (int k = 0; k < int'(WC); k++) begin
            cap[k] = dout;
            if (busy) busy_cycles++;
            send = (k == ign_at);
            @(negedge clk);
        end
        send = 1'b0;
        chk("busy_cycles", 32'(busy_cycles), 32'(WC));
        chk("end_dout", 32'(dout), 32'h7F);
        chk("end_playing", 32'(playing), 32'h1);
        chk("end_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (5) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h7F);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_playing", 32'(playing), 32'h0);

        // "HI"
        write_char("H", 1'b0);
        write_char("I", 1'b0);
        stream_collect(-1, 1'b0, 8'h00);
        chk("hi_w0", 32'(cap[0]), 32'h68);
        chk("hi_w1", 32'(cap[1]), 32'h69);
        chk("hi_w2", 32'(cap[2]), 32'h40);
        chk("hi_w19", 32'(cap[19]), 32'h40);

        // Encoding corner cases, written while in PLAY
        write_char("a", 1'b0);
        write_char("_", 1'b0);
        write_char(8'h0A, 1'b0);
        write_char(8'hFF, 1'b1);
        write_char("!", 1'b0);
        stream_collect(-1, 1'b0, 8'h00);
        chk("enc_a", 32'(cap[0]), 32'h61);
        chk("enc_us", 32'(cap[1]), 32'h5F);
        chk("enc_lf", 32'(cap[2]), 32'h5F);
        chk("enc_raw", 32'(cap[3]), 32'h3F);
        chk("enc_bang", 32'(cap[4]), 32'h41);
        chk("enc_pad", 32'(cap[5]), 32'h40);

        // Full buffer and overflow write
        for (int i = 0; i < int'(WC); i++) write_char(8'(8'h41 + i), 1'b0);
        chk("full_ready", 32'(in_ready), 32'h0);
        write_char("X", 1'b0);
        chk("full_ready_after", 32'(in_ready), 32'h0);
        stream_collect(-1, 1'b0, 8'h00);
        for (int i = 0; i < int'(WC); i++) chk("full_word", 32'(cap[i]), 32'(32'h61 + i));
        chk("ready_after_full", 32'(in_ready), 32'h1);

        // Write together with send
        write_char("B", 1'b0);
        stream_collect(-1, 1'b1, "Z");
        chk("same_w0", 32'(cap[0]), 32'h62);
        chk("same_w1", 32'(cap[1]), 32'h7A);
        chk("same_w2", 32'(cap[2]), 32'h40);

        // Reset mid-stream
        write_char("Q", 1'b0);
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        @(negedge clk);
        chk("mid_w0", 32'(dout), 32'h71);
        repeat (5) @(negedge clk);
        chk("mid_busy5", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_dout", 32'(dout), 32'h7F);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_play", 32'(playing), 32'h0);
        stream_collect(3, 1'b0, 8'h00);
        for (int i = 0; i < int'(WC); i++) chk("post_rst_space", 32'(cap[i]), 32'h40);
        repeat (10) @(negedge clk);
        chk("play_hold", 32'(playing), 32'h1);
        chk("play_dout", 32'(dout), 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
